keypad_scanner: RTL and testbench
=================================

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

Interface
REQ-001 The module SHALL have parameter SETTLE_CYCLES, default 16, giving the number of clk cycles each row is driven before its columns are sampled; legal range 3..255.
REQ-002 The module SHALL have parameter DEBOUNCE_SCANS, default 4, giving the number of consecutive full frames a key's raw state must differ from its debounced state before the debounced state flips; legal range 1..7.
REQ-003 clk  input  1  system clock; the module has one clock, and reset is synchronous and active-high.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 row_out  output  4  physical row drive, active-low, with exactly one row low while scanning.
REQ-006 col_in  input  4  physical column sense, active-low, pulled up externally, asynchronous.
REQ-007 keypad_matrix  output  16  debounced key state; bit n = hex key n; 1 = pressed; feeds the CPU keypad_matrix port.
REQ-008 key_event  output  1  one-cycle pulse on any released-to-pressed transition.
REQ-009 key_code  output  4  hex code of the lowest-numbered newly pressed key; valid when key_event=1 and held until the next event.

Function
REQ-010 col_in SHALL pass through a 2-flop synchronizer before use.
REQ-011 The scan FSM SHALL have the states DRIVE and UPDATE: DRIVE holds row r low for SETTLE_CYCLES cycles (settle counter 0..SETTLE_CYCLES-1), and samples on the cycle where counter=SETTLE_CYCLES-1.
REQ-012 A sample SHALL write raw[row r, col c] = ~col_sync[c] for c=0..3 and then advance r; after r=3 is sampled, r wraps to 0 and the FSM enters UPDATE for exactly 1 cycle before returning to DRIVE row 0.
REQ-013 Frame length SHALL be 4*SETTLE_CYCLES+1 cycles.
REQ-014 Physical (row,col) SHALL map to hex key per the layout 1 2 3 C / 4 5 6 D / 7 8 9 E / A 0 B F, with row 0 at the top and col 0 at the left.
REQ-015 In UPDATE, each key SHALL run its own 3-bit counter: if raw equals debounced, the counter is cleared; otherwise the counter increments, and when it reaches DEBOUNCE_SCANS the debounced bit flips and the counter clears.
REQ-016 keypad_matrix SHALL change only on the cycle after UPDATE and is registered.
REQ-017 If any key flips 0->1 in an UPDATE, key_event SHALL be 1 on the next cycle and key_code SHALL be the lowest such hex code; releases SHALL produce no event.
REQ-018 Simultaneous new presses SHALL produce a single event; higher codes are visible only in keypad_matrix.
REQ-019 Ghosting and masking from 3+ key combinations SHALL NOT be corrected; the bits report as sampled.
REQ-020 Worst-case press latency from a stable col_in edge to a keypad_matrix set SHALL be (DEBOUNCE_SCANS+1) frames + 3 cycles.

Reset
REQ-021 While reset=1: row_out=4'hF, keypad_matrix=0, key_event=0, key_code=0, raw=0, all debounce counters 0, synchronizer flops=4'hF, FSM=DRIVE, row=0, settle counter=0.
REQ-022 On the first cycle after reset deasserts, row_out SHALL be 4'hE.
REQ-023 Reset asserted mid-frame SHALL discard partial samples and take effect on the next clk edge.

Structure
REQ-024 A shared package keypad_pkg SHALL hold the FSM state enum and the 16-entry physical-to-hex KEYMAP constant.
REQ-025 A single sub-module, key_debounce (one instance per key: raw, update strobe -> debounced bit, rise pulse), SHALL be used and instantiated 16 times.

Verification (bench: SETTLE_CYCLES=4, DEBOUNCE_SCANS=3; frame=17 cycles; col_in model pulls a column low when its row is low and the key is closed)
REQ-026 Reset check: hold reset 5 cycles -> row_out=F, keypad_matrix=0000; first cycle after release row_out=E; row_out sequence E,D,B,7 at 4 cycles each, then 1 cycle E before the next frame.
REQ-027 Single press: close (row1,col2) -> keypad_matrix=16'h0040 within 4 frames+3 cycles; key_event pulses once with key_code=6; open the key -> bit 6 clears 3 frames later with no event.
REQ-028 Bounce: toggle (row0,col0) on alternate frames for 6 frames, then hold it closed -> no change or event during toggling; keypad_matrix[1] sets exactly 3 UPDATEs after hold begins.
REQ-029 Simultaneous press: close keys 1 (row0,col0) and F (row3,col3) in the same frame -> keypad_matrix=16'h8002; one key_event with key_code=1.
REQ-030 Reset mid-operation: with key 5 debounced pressed, assert reset at settle count 2 of row 2 -> keypad_matrix=0 next cycle; after release with the key still held, bit 5 reasserts after 3 frames and key_event fires with key_code=5.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: scan FSM states, physical-to-hex map, priority helper.
package keypad_pkg;

    localparam int unsigned ROWS  = 4;
    localparam int unsigned COLS  = 4;
    localparam int unsigned NKEYS = ROWS * COLS;

    typedef enum logic {
        ST_DRIVE  = 1'b0,
        ST_UPDATE = 1'b1
    } scan_state_e;

    // Index is row*4+col (row 0 top, col 0 left); value is the hex key printed on the cap.
    localparam logic [3:0] KEYMAP [NKEYS] = '{
        4'h1, 4'h2, 4'h3, 4'hC,
        4'h4, 4'h5, 4'h6, 4'hD,
        4'h7, 4'h8, 4'h9, 4'hE,
        4'hA, 4'h0, 4'hB, 4'hF
    };

    function automatic logic [3:0] lowest_set(input logic [15:0] v);
        logic [3:0] idx;
        idx = '0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) idx = 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Per-key debouncer: flips the debounced bit after DEBOUNCE_SCANS consecutive disagreeing frames.
module key_debounce
#(
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    input  logic update,
    output logic debounced,
    output logic rise_c
);

    logic [2:0] cnt_q, cnt_d;
    logic       deb_q, deb_d;

    always_comb begin
        cnt_d  = cnt_q;
        deb_d  = deb_q;
        rise_c = 1'b0;
        if (update) begin
            if (raw == deb_q) begin
                cnt_d = '0;
            end else if (3'(cnt_q + 3'd1) == 3'(DEBOUNCE_SCANS)) begin
                deb_d  = ~deb_q;
                cnt_d  = '0;
                rise_c = raw;
            end else begin
                cnt_d = 3'(cnt_q + 3'd1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            deb_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            deb_q <= deb_d;
        end
    end

    assign debounced = deb_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: row drive/sample FSM, per-key debounce, press event with lowest hex code.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES  = 16,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        reset,
    output logic [3:0]  row_out,
    input  logic [3:0]  col_in,
    output logic [15:0] keypad_matrix,
    output logic        key_event,
    output logic [3:0]  key_code
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    logic [3:0]       col_s1_q, col_s2_q;
    scan_state_e      state_q, state_d;
    logic [1:0]       row_q, row_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             started_q, started_d;
    logic [15:0]      raw_q, raw_d;
    logic [3:0]       row_out_q, row_out_d;
    logic             key_event_q, key_event_d;
    logic [3:0]       key_code_q, key_code_d;

    logic             update_c;
    logic [15:0]      deb_c, rise_c, matrix_c, rise_hex_c;

    // Scan sequencing; started_q holds the counter for one cycle so row 0 gets its full settle time after reset.
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        cnt_d       = cnt_q;
        raw_d       = raw_q;
        started_d   = 1'b1;
        if (started_q) begin
            case (state_q)
                ST_DRIVE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        cnt_d = '0;
                        raw_d[{row_q, 2'b00} +: 4] = ~col_s2_q;
                        row_d = 2'(row_q + 2'd1);
                        if (row_q == 2'd3) state_d = ST_UPDATE;
                    end else begin
                        cnt_d = CNT_W'(cnt_q + 1'b1);
                    end
                end
                ST_UPDATE: state_d = ST_DRIVE;
                default:   state_d = ST_DRIVE;
            endcase
        end
        row_out_d = ~(4'b0001 << row_d);
    end

    assign update_c = (state_q == ST_UPDATE);

    for (genvar p = 0; p < NKEYS; p++) begin : g_key
        key_debounce #(
            .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
        ) u_deb (
            .clk       (clk),
            .reset     (reset),
            .raw       (raw_q[p]),
            .update    (update_c),
            .debounced (deb_c[p]),
            .rise_c    (rise_c[p])
        );
    end

    // Remap physical positions to hex-key bit positions.
    always_comb begin
        matrix_c   = '0;
        rise_hex_c = '0;
        for (int p = 0; p < NKEYS; p++) begin
            matrix_c[KEYMAP[p]]   = deb_c[p];
            rise_hex_c[KEYMAP[p]] = rise_c[p];
        end
        key_event_d = |rise_hex_c;
        key_code_d  = (|rise_hex_c) ? lowest_set(rise_hex_c) : key_code_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col_s1_q    <= 4'hF;
            col_s2_q    <= 4'hF;
            state_q     <= ST_DRIVE;
            row_q       <= '0;
            cnt_q       <= '0;
            started_q   <= 1'b0;
            raw_q       <= '0;
            row_out_q   <= 4'hF;
            key_event_q <= 1'b0;
            key_code_q  <= '0;
        end else begin
            col_s1_q    <= col_in;
            col_s2_q    <= col_s1_q;
            state_q     <= state_d;
            row_q       <= row_d;
            cnt_q       <= cnt_d;
            started_q   <= started_d;
            raw_q       <= raw_d;
            row_out_q   <= row_out_d;
            key_event_q <= key_event_d;
            key_code_q  <= key_code_d;
        end
    end

    assign row_out       = row_out_q;
    assign keypad_matrix = matrix_c;
    assign key_event     = key_event_q;
    assign key_code      = key_code_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner (SETTLE_CYCLES=4, DEBOUNCE_SCANS=3, 17-cycle frames).
module tb_keypad_scanner;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  row_out;
    logic [3:0]  col_in;
    logic [15:0] keypad_matrix;
    logic        key_event;
    logic [3:0]  key_code;

    logic [15:0] keys = '0;
    int          cyc = -1;
    int          tests = 0;
    int          fails = 0;
    bit          mon_en = 1'b0;
    logic [15:0] prev_mat = '0;

    typedef struct {
        logic [15:0] val;
        int          cyc;
    } exp_t;

    exp_t exp_ev[$];
    exp_t exp_mat[$];

    always #5 clk = ~clk;

    keypad_scanner #(
        .SETTLE_CYCLES  (4),
        .DEBOUNCE_SCANS (3)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .row_out       (row_out),
        .col_in        (col_in),
        .keypad_matrix (keypad_matrix),
        .key_event     (key_event),
        .key_code      (key_code)
    );

    // Closed key pulls its column low while its row is driven low.
    always_comb begin
        col_in = 4'hF;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (keys[r*4+c] && (row_out[r] == 1'b0)) col_in[c] = 1'b0;
            end
        end
    end

    always @(posedge clk) cyc <= reset ? -1 : cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp_v, cyc);
        end
    endtask

    task automatic wait_cyc(input int target);
        int n;
        n = 0;
        while (cyc != target) begin
            @(negedge clk);
            n++;
            if (n > 2000) begin
                tests++;
                fails++;
                $display("FAIL wait_cyc timeout: at cyc %0d expected %0d", cyc, target);
                return;
            end
        end
    endtask

    task automatic push_ev(input logic [3:0] code, input int c);
        exp_t e;
        e.val = 16'(code);
        e.cyc = c;
        exp_ev.push_back(e);
    endtask

    task automatic push_mat(input logic [15:0] v, input int c);
        exp_t e;
        e.val = v;
        e.cyc = c;
        exp_mat.push_back(e);
    endtask

    // Monitor: pops the scoreboard whenever the DUT pulses an event or changes its matrix.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en) begin
            if (key_event !== 1'b0) begin
                if (exp_ev.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_event: key_event=%b code=%h cyc %0d", key_event, key_code, cyc);
                end else begin
                    e = exp_ev.pop_front();
                    check("event_code", 32'(key_code), 32'(e.val));
                    check("event_cyc", 32'(cyc), 32'(e.cyc));
                end
            end
            if (keypad_matrix !== prev_mat) begin
                if (exp_mat.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_matrix: got %h cyc %0d", keypad_matrix, cyc);
                end else begin
                    e = exp_mat.pop_front();
                    check("matrix_val", 32'(keypad_matrix), 32'(e.val));
                    check("matrix_cyc", 32'(cyc), 32'(e.cyc));
                end
                prev_mat = keypad_matrix;
            end
        end
    end

    initial begin
        logic [3:0] er;
        reset = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_row_out", 32'(row_out), 32'h0000_000F);
        check("rst_matrix", 32'(keypad_matrix), 32'h0);
        check("rst_event", 32'(key_event), 32'h0);
        check("rst_code", 32'(key_code), 32'h0);
        prev_mat = '0;
        mon_en = 1'b1;
        reset = 1'b0;

        // Row drive pattern across the first frame
        for (int i = 0; i < 17; i++) begin
            wait_cyc(i);
            er = (i < 16) ? ~(4'b0001 << (i / 4)) : 4'hE;
            check("row_out_seq", 32'(row_out), 32'(er));
        end

        // Single press at (row1,col2) = key 6, then release
        keys[6] = 1'b1;
        push_mat(16'h0040, 68);
        push_ev(4'h6, 68);
        wait_cyc(100);
        check("code_hold_6", 32'(key_code), 32'h6);
        wait_cyc(101);
        keys[6] = 1'b0;
        push_mat(16'h0000, 153);

        // Bounce on (row0,col0) = key 1 for six frames, then hold
        for (int i = 0; i < 6; i++) begin
            wait_cyc(17 * (9 + i) + 16);
            keys[0] = (i % 2 == 0);
        end
        wait_cyc(271);
        keys[0] = 1'b1;
        push_mat(16'h0002, 323);
        push_ev(4'h1, 323);
        wait_cyc(356);
        keys[0] = 1'b0;
        push_mat(16'h0000, 408);
        wait_cyc(400);
        check("code_hold_1", 32'(key_code), 32'h1);

        // Simultaneous press of keys 1 and F
        wait_cyc(441);
        keys[0]  = 1'b1;
        keys[15] = 1'b1;
        push_mat(16'h8002, 493);
        push_ev(4'h1, 493);
        wait_cyc(526);
        keys = '0;
        push_mat(16'h0000, 578);

        // Key 5 held, then reset mid-frame at row 2 settle count 2
        wait_cyc(611);
        keys[5] = 1'b1;
        push_mat(16'h0020, 663);
        push_ev(4'h5, 663);
        wait_cyc(690);
        reset = 1'b1;
        push_mat(16'h0000, -1);
        @(negedge clk);
        check("midrst_row_out", 32'(row_out), 32'h0000_000F);
        check("midrst_code", 32'(key_code), 32'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        push_mat(16'h0020, 51);
        push_ev(4'h5, 51);
        wait_cyc(70);
        check("ev_queue_empty", 32'(exp_ev.size()), 32'h0);
        check("mat_queue_empty", 32'(exp_mat.size()), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
